// File: rtl/fp16_mul_arb_pkg.sv
// Shared constants and types for the FP16 multiplier arbiter slice.
// FP16_MUL_LAT must track the stage count of the external fp16_mul.
package fp16_mul_arb_pkg;
    localparam int FP16_W       = 16;
    localparam int FP16_MUL_LAT = 2;

    typedef logic [FP16_W-1:0] fp16_t;
endpackage

// File: rtl/fp16_mul_arb_if.sv
// Requester-side bundle: operand handshake plus per-requester response buffer.
interface fp16_mul_arb_if
    import fp16_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [FP16_W*N_REQ-1:0] req_a;
    logic [FP16_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [FP16_W*N_REQ-1:0] rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fp16_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
// Shared between the FP16 operator arbiters.
module fp16_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int TAG_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [TAG_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [TAG_W-1:0] grant_idx
);
    always_comb begin
        int   idx;
        logic found;
        // NOTE: every output gets a default before the search so no path can leave it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // NOTE: blocking (=) is required here: 'found' must be seen by the later loop iterations.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && elig[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = TAG_W'(idx);
            end
        end
    end
endmodule

// File: rtl/fp16_mul_arb.sv
// Shares one pipelined fp16_mul among N_REQ requesters; a tag pipeline matched to
// the multiplier latency routes each product back to its one-entry response buffer.
module fp16_mul_arb
    import fp16_mul_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = FP16_MUL_LAT,
    parameter int TAG_W   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp16_mul_arb_if.slave        bus,
    output fp16_t                mul_a,
    output fp16_t                mul_b,
    input  fp16_t                mul_result,
    output logic                 busy
);
    logic [N_REQ-1:0]              outstanding;
    logic [N_REQ-1:0]              pop;
    logic [N_REQ-1:0]              elig;
    logic [N_REQ-1:0]              grant;
    logic [TAG_W-1:0]              grant_idx;
    logic [TAG_W-1:0]              rr_ptr;
    logic [MUL_LAT:0]              stg_vld;
    logic [MUL_LAT:0][TAG_W-1:0]   stg_tag;
    logic [N_REQ-1:0]              rsp_vld;
    logic [N_REQ-1:0][FP16_W-1:0]  rsp_buf;
    logic [N_REQ-1:0][FP16_W-1:0]  req_a_w;
    logic [N_REQ-1:0][FP16_W-1:0]  req_b_w;
    logic                          land;
    logic [TAG_W-1:0]              land_tag;

    assign req_a_w = bus.req_a;
    assign req_b_w = bus.req_b;
    assign pop     = rsp_vld & bus.rsp_ready;
    // A requester whose buffer pops this cycle may re-issue at once; nothing is granted in reset.
    assign elig    = bus.req_valid & (~outstanding | pop) & {N_REQ{rst_n}};

    fp16_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .elig      (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign land     = stg_vld[MUL_LAT];
    assign land_tag = stg_tag[MUL_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= TAG_W'(N_REQ - 1);
            outstanding <= '0;
            stg_vld     <= '0;
            stg_tag     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_vld     <= '0;
            // NOTE: the response buffers are cleared in reset because rsp_data is visible and must read zero.
            rsp_buf     <= '0;
        end else begin
            // NOTE: non-blocking (<=) for all state so every register samples pre-edge values.
            stg_vld     <= {stg_vld[MUL_LAT-1:0], |grant};
            stg_tag     <= {stg_tag[MUL_LAT-1:0], grant_idx};
            outstanding <= (outstanding & ~pop) | grant;
            if (|grant) begin
                rr_ptr <= grant_idx;
                mul_a  <= req_a_w[grant_idx];
                mul_b  <= req_b_w[grant_idx];
            end else begin
                mul_a  <= '0;
                mul_b  <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (land && land_tag == TAG_W'(i)) begin
                    rsp_vld[i] <= 1'b1;
                    rsp_buf[i] <= mul_result;
                end else if (pop[i]) begin
                    rsp_vld[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_data  = rsp_buf;
    assign busy          = (|stg_vld) | (|rsp_vld);
endmodule
